// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed-BCD converter with start/done handshake.
// Optional leading-zero blanking is enabled with `define BCD_LEAD_ZERO_BLANK_EN.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overflow,
  output state_e                    dbg_state
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Handshake: start is taken only in IDLE when no done pulse is showing;
  // busy covers the cycle after the accepted start through the done cycle.
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted_bcd;
  logic [BIN_W-1:0]   shifted_bin;
  logic               carry_out;
  logic [BCD_W-1:0]   disp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .dout (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit falling off the top digit lands in carry_out (overflow capture).
  assign {carry_out, shifted_bcd, shifted_bin} = {adj, shift_q, 1'b0};

  always_comb begin
    disp = bcd_q;
`ifdef BCD_LEAD_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      // Digit 0 is never blanked so a zero result still shows "0".
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && (bcd_q[k*DIGIT_W +: DIGIT_W] == 4'd0)) begin
          disp[k*DIGIT_W +: DIGIT_W] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    bcd_out_d  = bcd_out_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          shift_d = bin_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = shifted_bcd;
        shift_d = shifted_bin;
        ovf_d   = ovf_q | carry_out |
                  (shifted_bcd[BCD_W-1 -: DIGIT_W] > 4'd9);
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (ovf_q) begin
          bcd_out_d  = {DIGITS{BCD_NINE}};
          overflow_d = 1'b1;
        end else begin
          bcd_out_d  = disp;
          overflow_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = bcd_out_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq (either blanking build).
module tb_bin_to_bcd_seq;
  import bin_to_bcd_seq_pkg::*;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = 28;

  logic              clk;
  logic              reset;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [31:0]       bcd_out;
  logic              overflow;
  state_e            dbg_state;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [31:0]      bcd;
    logic             ovf;
  } vec_t;

  vec_t vecs[10];

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One conversion. poke_cyc > 0 re-asserts start with poke_val at that cycle
  // (cycle LAT = the done cycle); bin_in is scrambled while busy.
  task automatic run_conv(input logic [BIN_W-1:0] v, input int poke_cyc,
                          input logic [BIN_W-1:0] poke_val,
                          output logic [31:0] got_bcd, output logic got_ovf,
                          output int lat, output logic busy_ok,
                          output logic hold_ok, output logic idle_ok);
    logic [31:0] prev;
    prev    = bcd_out;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat     = -1;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (!busy) busy_ok = 1'b0;
      if (!done && bcd_out !== prev) hold_ok = 1'b0;
      if (c == poke_cyc) begin
        start  = 1'b1;
        bin_in = poke_val;
      end else begin
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    got_bcd = bcd_out;
    got_ovf = overflow;
    @(posedge clk);
    #1;
    start   = 1'b0;
    idle_ok = !done && !busy && (dbg_state == IDLE);
  endtask

  task automatic do_vec(input string tag, input vec_t vv, input int poke_cyc,
                        input logic [BIN_W-1:0] poke_val);
    logic [31:0] g_bcd;
    logic        g_ovf, b_ok, h_ok, i_ok;
    int          lat;
    run_conv(vv.bin, poke_cyc, poke_val, g_bcd, g_ovf, lat, b_ok, h_ok, i_ok);
    check({tag, " latency"},  32'(lat), 32'(LAT));
    check({tag, " bcd_out"},  g_bcd, vv.bcd);
    check({tag, " overflow"}, 32'(g_ovf), 32'(vv.ovf));
    check({tag, " busy_span"}, 32'(b_ok), 32'd1);
    check({tag, " bcd_hold"}, 32'(h_ok), 32'd1);
    check({tag, " idle_after"}, 32'(i_ok), 32'd1);
  endtask

  initial begin
    logic saw_done;
    n_tests = 0;
    n_fail  = 0;

`ifdef BCD_LEAD_ZERO_BLANK_EN
    vecs[0] = '{27'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{27'd99999999,  32'h99999999, 1'b0};
    vecs[2] = '{27'd100000000, 32'h99999999, 1'b1};
    vecs[3] = '{27'd0,         32'hFFFFFFF0, 1'b0};
    vecs[4] = '{27'd305,       32'hFFFFF305, 1'b0};
    vecs[5] = '{27'd134217727, 32'h99999999, 1'b1};
    vecs[6] = '{27'd90000009,  32'h90000009, 1'b0};
    vecs[7] = '{27'd10000000,  32'h10000000, 1'b0};
    vecs[8] = '{27'd7,         32'hFFFFFFF7, 1'b0};
    vecs[9] = '{27'd1000,      32'hFFFF1000, 1'b0};
`else
    vecs[0] = '{27'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{27'd99999999,  32'h99999999, 1'b0};
    vecs[2] = '{27'd100000000, 32'h99999999, 1'b1};
    vecs[3] = '{27'd0,         32'h00000000, 1'b0};
    vecs[4] = '{27'd305,       32'h00000305, 1'b0};
    vecs[5] = '{27'd134217727, 32'h99999999, 1'b1};
    vecs[6] = '{27'd90000009,  32'h90000009, 1'b0};
    vecs[7] = '{27'd10000000,  32'h10000000, 1'b0};
    vecs[8] = '{27'd7,         32'h00000007, 1'b0};
    vecs[9] = '{27'd1000,      32'h00001000, 1'b0};
`endif

    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst bcd_out",  bcd_out, 32'h0);
    check("rst busy",     32'(busy), 32'd0);
    check("rst done",     32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst state",    32'(dbg_state), 32'(IDLE));

    // back-to-back conversions: each start lands in the cycle after done
    for (int i = 0; i < 10; i++) begin
      do_vec($sformatf("vec%0d", i), vecs[i], 0, '0);
    end

    // start pulse mid-conversion ignored; first result stands
    do_vec("busy_start", vecs[0], 10, 27'd42);
    // start during the done cycle ignored (idle_after would see busy)
    do_vec("done_start", vecs[6], LAT, 27'd55);

    // reset mid-conversion: async clear, no done pulse
    @(negedge clk);
    bin_in = 27'd12345678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort bcd_out",  bcd_out, 32'h0);
    check("abort busy",     32'(busy), 32'd0);
    check("abort done",     32'(done), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    check("abort state",    32'(dbg_state), 32'(IDLE));
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    do_vec("after_abort", vecs[4], 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter: binary value in, DIGITS packed BCD digits out.
- Sits directly upstream of the 8-digit time-multiplexed seven-segment display; bcd_out nibble k feeds display digit k (digit 0 = rightmost, least significant).
- Start/done handshake. Result register holds its value between conversions, so the display never sees intermediate data.

Parameters:
- BIN_W, 27, width of binary input; 27 bits covers 0..99,999,999.
- DIGITS, 8, number of BCD output digits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (assert 0 = reset).
- start  in  1  request conversion; sampled only in IDLE.
- bin_in  in  BIN_W  binary value; captured on the accepted start cycle only.
- busy  out  1  high from cycle after accepted start until done cycle inclusive.
- done  out  1  one-cycle pulse; bcd_out/overflow valid and updated in this cycle.
- bcd_out  out  4*DIGITS  packed result; nibble k = digit k.
- overflow  out  1  last conversion exceeded 10^DIGITS-1.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, overflow=0, bcd_out=all zero; shift count and scratch registers cleared.
- States:
  - IDLE: start=1 -> load shift reg with bin_in, clear BCD scratch, clear overflow scratch, cnt=BIN_W, go SHIFT.
  - SHIFT: each cycle, every scratch digit >=5 gets +3, then the {scratch, shift reg} concatenation shifts left by 1; cnt decrements; cnt reaching 0 after the shift -> go DONE.
  - DONE: register result into bcd_out/overflow, done=1 for this one cycle, return to IDLE.
- Latency: start accepted at edge 0; done=1 in the cycle after edge BIN_W+1 (28 cycles for default). Fixed, data-independent.
- Overflow: a 1 shifted out of the top scratch digit, or a top digit that would exceed 9, sets sticky overflow scratch. In DONE with overflow: bcd_out = all digits 9, overflow=1. Otherwise overflow=0.
- start while busy or in DONE is ignored; no queueing. start in the cycle after DONE (IDLE) is accepted normally.
- bin_in changes during conversion have no effect.
- bcd_out changes only in the DONE cycle; it holds across IDLE and SHIFT.
- Reset mid-conversion aborts immediately; no done pulse is produced.
- Arithmetic: per-digit add-3 is 4-bit, no carry between digits. Scratch width is 4*DIGITS plus 1 overflow-capture bit.

Optional Feature:
- Macro BCD_LEAD_ZERO_BLANK_EN.
- Defined: in DONE (non-overflow case), leading-zero digits above the most significant nonzero digit are replaced by code 4'hF, which the downstream driver treats as blank. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits emitted as plain BCD, leading zeros included.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT, DONE};
  - DIGIT_W=4;
  - BCD_BLANK=4'hF;
  - BCD_NINE=4'h9.
- Sub-module bcd_add3: combinational 4-bit cell, in>=5 ? in+3 : in. Instantiated DIGITS times via generate. Top module holds FSM, counter, registers and blanking.

Test Plan:
- Reset low for 3 cycles then release, no start -> bcd_out=0x00000000, busy=0, done=0, overflow=0.
- bin_in=12,345,678, start 1 cycle -> done exactly 28 cycles later, bcd_out=0x12345678, overflow=0; busy high for cycles 1..28.
- bin_in=99,999,999 -> bcd_out=0x99999999, overflow=0; then bin_in=100,000,000 -> bcd_out=0x99999999, overflow=1.
- bin_in=0 -> bcd_out=0x00000000. With BCD_LEAD_ZERO_BLANK_EN, bin_in=0 -> 0xFFFFFFF0 and bin_in=305 -> 0xFFFFF305.
- start pulsed again at cycle 10 with different bin_in -> ignored, first result returned. start in the cycle after done -> second conversion accepted, correct result.
- reset asserted at cycle 15 of a conversion -> outputs clear asynchronously, no done pulse. New start after release -> correct result 28 cycles later.
